// File: rtl/synth_mix_pkg.sv
// Shared constants and state type for the time-multiplexed voice mixer.
package synth_mix_pkg;

  localparam int unsigned NVOICE = 8;
  localparam int unsigned DW     = 16;
  // Three guard bits hold the sum of eight full-scale samples.
  localparam int unsigned ACCW   = DW + 3;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} mix_state_t;

endpackage

// File: rtl/voice_mixer_if.sv
// Mixer-side signals: tick and enables in, mux select out, mux data back, mix result out.
interface voice_mixer_if;
  import synth_mix_pkg::*;

  logic                   sample_tick;
  logic [NVOICE-1:0]      voice_en;
  logic [NVOICE-1:0]      oneHot;
  logic signed [DW-1:0]   mux_data;
  logic signed [DW-1:0]   mix_out;
  logic                   mix_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output sample_tick, voice_en, mux_data,
    input  oneHot, mix_out, mix_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, voice_en, mux_data,
    output oneHot, mix_out, mix_valid, busy, overrun
  );

endinterface

// File: rtl/voice_mixer_sat_shift.sv
// Arithmetic right shift of the accumulator followed by clamping to the signed DW range.
module sat_shift #(
  parameter int unsigned ACCW  = 19,
  parameter int unsigned DW    = 16,
  parameter int unsigned SHIFT = 2
) (
  input  logic signed [ACCW-1:0] din,
  output logic signed [DW-1:0]   dout
);

  localparam logic signed [ACCW-1:0] MaxV = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] MinV = ~MaxV;

  logic signed [ACCW-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    if (shifted > MaxV) begin
      dout = MaxV[DW-1:0];
    end else if (shifted < MinV) begin
      dout = MinV[DW-1:0];
    end else begin
      dout = shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// 8-voice mixer: walks a one-hot mux select per tick, sums enabled voices, emits a scaled mix.
module voice_mixer
  import synth_mix_pkg::*;
#(
  parameter int unsigned SHIFT = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  voice_mixer_if.slave   bus
);

  mix_state_t              state_q;
  logic [NVOICE-1:0]       one_hot_q;
  logic [NVOICE-1:0]       en_q;
  logic signed [ACCW-1:0]  acc_q;
  logic signed [DW-1:0]    mix_out_q;
  logic                    mix_valid_q;
  logic                    busy_q;
  logic                    overrun_q;
  logic signed [DW-1:0]    sat_val;
  logic signed [ACCW-1:0]  sample_ext;

  assign sample_ext = {{(ACCW - DW){bus.mux_data[DW-1]}}, bus.mux_data};

  sat_shift #(
    .ACCW  (ACCW),
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (acc_q),
    .dout (sat_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      one_hot_q   <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mix_valid_q <= 1'b0;
      // Any tick outside IDLE is dropped and latched as an overrun.
      if (bus.sample_tick && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.sample_tick) begin
            en_q      <= bus.voice_en;
            acc_q     <= '0;
            one_hot_q <= NVOICE'(1);
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if ((en_q & one_hot_q) != '0) begin
            acc_q <= acc_q + sample_ext;
          end
          if (one_hot_q[NVOICE-1]) begin
            one_hot_q <= '0;
            state_q   <= DONE;
          end else begin
            one_hot_q <= one_hot_q << 1;
          end
        end
        DONE: begin
          mix_out_q   <= sat_val;
          mix_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oneHot    = one_hot_q;
  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: two instances (SHIFT=2 and SHIFT=0) checked against a frame-level sum model.
module tb_voice_mixer;

  logic clk;
  logic reset_n;
  logic tick;
  logic [7:0] ven;
  logic signed [15:0] smp [8];

  int n_checks;
  int n_fail;

  voice_mixer_if if2 ();
  voice_mixer_if if0 ();

  voice_mixer #(.SHIFT(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  voice_mixer #(.SHIFT(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] pick(input logic [7:0] oh);
    logic signed [15:0] r;
    r = 16'sh1234;
    for (int i = 0; i < 8; i++) if (oh[i]) r = smp[i];
    return r;
  endfunction

  assign if2.sample_tick = tick;
  assign if0.sample_tick = tick;
  assign if2.voice_en    = ven;
  assign if0.voice_en    = ven;
  always_comb if2.mux_data = pick(if2.oneHot);
  always_comb if0.mux_data = pick(if0.oneHot);

  // Mix = clamp(floor(sum of enabled samples / 2**sh)).
  function automatic logic signed [15:0] model(input logic [7:0] en, input int sh);
    longint s;
    s = 0;
    for (int i = 0; i < 8; i++) if (en[i]) s += longint'(smp[i]);
    s = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 50; c++) begin
      step();
      n_checks++;
      if (if2.oneHot !== 8'h00 || if0.oneHot !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_onehot c=%0d got %h/%h want 00", c, if2.oneHot, if0.oneHot);
      end
      n_checks++;
      if (if2.mix_out !== 16'sd0 || if0.mix_out !== 16'sd0) begin
        n_fail++;
        $display("FAIL reset_mix_out c=%0d got %0d/%0d want 0", c, if2.mix_out, if0.mix_out);
      end
      n_checks++;
      if ({if2.mix_valid, if0.mix_valid, if2.busy, if0.busy, if2.overrun, if0.overrun}
          !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_flags c=%0d got v%b%b b%b%b o%b%b want all 0", c,
                 if2.mix_valid, if0.mix_valid, if2.busy, if0.busy, if2.overrun, if0.overrun);
      end
    end
  endtask

  // One full frame from the tick cycle; voice_en is scrambled after the tick to test the snapshot.
  task automatic run_frame(input string name, input logic [7:0] en);
    logic signed [15:0] e2;
    logic signed [15:0] e0;
    logic [7:0] exp_oh;
    e2 = model(en, 2);
    e0 = model(en, 0);
    ven  = en;
    tick = 1'b1;
    step();
    tick = 1'b0;
    ven  = 8'($urandom);
    for (int c = 1; c <= 11; c++) begin
      exp_oh = (c <= 8) ? 8'(1 << (c - 1)) : 8'h00;
      n_checks++;
      if (if2.oneHot !== exp_oh || if0.oneHot !== exp_oh) begin
        n_fail++;
        $display("FAIL %s_onehot c=%0d got %h/%h want %h", name, c, if2.oneHot, if0.oneHot,
                 exp_oh);
      end
      n_checks++;
      if (if2.busy !== (c <= 9) || if0.busy !== (c <= 9)) begin
        n_fail++;
        $display("FAIL %s_busy c=%0d got %b/%b want %b", name, c, if2.busy, if0.busy, c <= 9);
      end
      n_checks++;
      if (if2.mix_valid !== (c == 10) || if0.mix_valid !== (c == 10)) begin
        n_fail++;
        $display("FAIL %s_valid c=%0d got %b/%b want %b", name, c, if2.mix_valid,
                 if0.mix_valid, c == 10);
      end
      if (c >= 10) begin
        n_checks++;
        if (if2.mix_out !== e2 || if0.mix_out !== e0) begin
          n_fail++;
          $display("FAIL %s_mix_out c=%0d got %0d/%0d want %0d/%0d", name, c, if2.mix_out,
                   if0.mix_out, e2, e0);
        end
      end
      if (c < 11) step();
    end
  endtask

  task automatic test_unity();
    for (int i = 0; i < 8; i++) smp[i] = 16'sd1000;
    run_frame("all1000", 8'hFF);
  endtask

  task automatic test_sparse();
    for (int i = 0; i < 8; i++) smp[i] = 16'sd30000;
    smp[0] = -16'sd4000;
    smp[2] = -16'sd8000;
    run_frame("sparse", 8'h05);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) smp[i] = 16'sd32767;
    run_frame("sat_pos", 8'hFF);
    for (int i = 0; i < 8; i++) smp[i] = -16'sd32768;
    run_frame("sat_neg", 8'hFF);
  endtask

  task automatic test_empty();
    for (int i = 0; i < 8; i++) smp[i] = 16'(-1000 * (i + 1));
    run_frame("empty", 8'h00);
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
      run_frame("random", 8'($urandom));
    end
  endtask

  // Ticks at cycles 0, 4, 9 and 10: the middle two are dropped, the last starts frame two.
  task automatic test_back_to_back();
    logic signed [15:0] e2;
    logic signed [15:0] e0;
    for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
    ven = 8'hA7;
    e2 = model(8'hA7, 2);
    e0 = model(8'hA7, 0);
    for (int k = 0; k < 21; k++) begin
      tick = (k == 0 || k == 4 || k == 9 || k == 10);
      step();
      n_checks++;
      if (if2.overrun !== (k >= 4) || if0.overrun !== (k >= 4)) begin
        n_fail++;
        $display("FAIL b2b_overrun c=%0d got %b/%b want %b", k + 1, if2.overrun, if0.overrun,
                 k >= 4);
      end
      n_checks++;
      if (if2.mix_valid !== (k == 9 || k == 19) || if0.mix_valid !== (k == 9 || k == 19)) begin
        n_fail++;
        $display("FAIL b2b_valid c=%0d got %b/%b want %b", k + 1, if2.mix_valid,
                 if0.mix_valid, k == 9 || k == 19);
      end
      if (k == 10) begin
        n_checks++;
        if (if2.oneHot !== 8'h01 || if0.oneHot !== 8'h01) begin
          n_fail++;
          $display("FAIL b2b_restart c=11 got %h/%h want 01", if2.oneHot, if0.oneHot);
        end
      end
      if (k == 19) begin
        n_checks++;
        if (if2.mix_out !== e2 || if0.mix_out !== e0) begin
          n_fail++;
          $display("FAIL b2b_mix_out c=20 got %0d/%0d want %0d/%0d", if2.mix_out, if0.mix_out,
                   e2, e0);
        end
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) smp[i] = 16'sd5000;
    ven  = 8'hFF;
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({if2.oneHot, if0.oneHot} !== 16'h0 || if2.mix_out !== 16'sd0 || if0.mix_out !== 16'sd0
        || {if2.mix_valid, if0.mix_valid, if2.busy, if0.busy, if2.overrun, if0.overrun}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got oh=%h/%h mix=%0d/%0d b=%b%b o=%b%b want all 0",
               if2.oneHot, if0.oneHot, if2.mix_out, if0.mix_out, if2.busy, if0.busy,
               if2.overrun, if0.overrun);
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      n_checks++;
      if ({if2.mix_valid, if0.mix_valid, if2.busy, if0.busy} !== 4'b0
          || {if2.oneHot, if0.oneHot} !== 16'h0) begin
        n_fail++;
        $display("FAIL postreset_quiet c=%0d got v%b%b b%b%b oh=%h/%h want 0", c,
                 if2.mix_valid, if0.mix_valid, if2.busy, if0.busy, if2.oneHot, if0.oneHot);
      end
    end
    run_frame("postreset", 8'h3C);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    tick     = 1'b0;
    ven      = 8'h00;
    for (int i = 0; i < 8; i++) smp[i] = 16'sd0;
    repeat (3) step();
    reset_n = 1'b1;
    test_reset();
    test_unity();
    test_sparse();
    test_saturation();
    test_empty();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
